// File: rtl/anchor_ebi_rd_ctrl_if.sv
// rtl/anchor_ebi_rd_ctrl_if.sv - FIFO and EBI data-path signals of the read-side frame controller
interface anchor_ebi_rd_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 12
);
  logic              rd_ena;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] ebi_dout;
  logic              ebi_irq;

  modport slave (
    input  rd_ena, fifo_dout, fifo_empty, fifo_count,
    output fifo_rd_en, ebi_dout, ebi_irq
  );

  modport master (
    output rd_ena, fifo_dout, fifo_empty, fifo_count,
    input  fifo_rd_en, ebi_dout, ebi_irq
  );
endinterface

// File: rtl/anchor_ebi_rd_ctrl.sv
// rtl/anchor_ebi_rd_ctrl.sv - EBI read frame controller: frame IRQ, per-strobe FIFO pop, underflow/timeout drain
module anchor_ebi_rd_ctrl #(
  parameter int                DATA_W         = 16,
  parameter int                CNT_W          = 12,
  parameter int                FRAME_WORDS    = 64,
  parameter int                TIMEOUT        = 65535,
  parameter logic [DATA_W-1:0] UNDERFLOW_WORD = 16'hDEAD
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  anchor_ebi_rd_ctrl_if.slave  bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_underflow,
  output logic                 err_timeout,
  input  logic                 err_clr
);
  localparam int WC_W = $clog2(FRAME_WORDS + 1);
  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);
  localparam logic [WC_W-1:0]  FRAME_WC  = WC_W'(FRAME_WORDS);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, ARMED, READING, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] word_cnt, wc_nxt, wc_inc;
  logic [TO_W-1:0] to_cnt, to_nxt;
  logic            rd_ena_q, strobe;
  logic            pop, load_word, uf_evt, to_evt, irq_set, irq_clr;

  // one strobe per NRDE assertion, however long the MCU holds it
  assign strobe         = bus.rd_ena & ~rd_ena_q;
  assign wc_inc         = word_cnt + WC_W'(1);
  assign bus.fifo_rd_en = pop;
  assign busy           = (state != IDLE);
  assign frame_done     = (state == DONE);

  always_comb begin
    state_nxt = state;
    wc_nxt    = word_cnt;
    to_nxt    = to_cnt;
    pop       = 1'b0;
    load_word = 1'b0;
    uf_evt    = 1'b0;
    to_evt    = 1'b0;
    irq_set   = 1'b0;
    irq_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fifo_count >= FRAME_CNT) begin
          state_nxt = ARMED;
          irq_set   = 1'b1;
        end
        if (strobe) uf_evt = 1'b1;
      end
      ARMED: begin
        if (strobe) begin
          irq_clr = 1'b1;
          to_nxt  = '0;
          wc_nxt  = WC_W'(1);
          if (!bus.fifo_empty) begin
            pop       = 1'b1;
            load_word = 1'b1;
          end else begin
            uf_evt = 1'b1;
          end
          state_nxt = (FRAME_WORDS == 1) ? DONE : READING;
        end
      end
      READING: begin
        if (strobe) begin
          to_nxt = '0;
          wc_nxt = wc_inc;
          if (!bus.fifo_empty) begin
            pop       = 1'b1;
            load_word = 1'b1;
          end else begin
            uf_evt = 1'b1;
          end
          if (wc_inc == FRAME_WC) state_nxt = DONE;
        end else begin
          to_nxt = to_cnt + TO_W'(1);
          if (to_cnt == TO_LAST) begin
            to_evt    = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        to_nxt = '0;
        // MCU reads here get the marker word; only drain pops advance the frame
        if (strobe) uf_evt = 1'b1;
        if (!bus.fifo_empty) begin
          pop    = 1'b1;
          wc_nxt = wc_inc;
          if (wc_inc == FRAME_WC) begin
            wc_nxt    = '0;
            state_nxt = IDLE;
          end
        end
      end
      DONE: begin
        wc_nxt    = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state         <= IDLE;
      word_cnt      <= '0;
      to_cnt        <= '0;
      rd_ena_q      <= 1'b0;
      bus.ebi_dout  <= '0;
      bus.ebi_irq   <= 1'b0;
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_cnt <= wc_nxt;
      to_cnt   <= to_nxt;
      rd_ena_q <= bus.rd_ena;
      if (load_word)   bus.ebi_dout <= bus.fifo_dout;
      else if (uf_evt) bus.ebi_dout <= UNDERFLOW_WORD;
      if (irq_set)      bus.ebi_irq <= 1'b1;
      else if (irq_clr) bus.ebi_irq <= 1'b0;
      // a new event outranks a simultaneous clear
      err_underflow <= uf_evt | (err_underflow & ~err_clr);
      err_timeout   <= to_evt | (err_timeout & ~err_clr);
    end
  end
endmodule

// File: tb/tb_anchor_ebi_rd_ctrl.sv
// tb/tb_anchor_ebi_rd_ctrl.sv - directed vector bench for anchor_ebi_rd_ctrl
module tb_anchor_ebi_rd_ctrl;
  logic rd_clk = 1'b0;
  logic rd_rst_n;
  logic err_clr;
  logic busy, frame_done, err_underflow, err_timeout;

  anchor_ebi_rd_ctrl_if #(.DATA_W(16), .CNT_W(12)) bus ();

  anchor_ebi_rd_ctrl #(
    .DATA_W(16), .CNT_W(12), .FRAME_WORDS(4), .TIMEOUT(16), .UNDERFLOW_WORD(16'hDEAD)
  ) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .bus(bus),
    .busy(busy), .frame_done(frame_done),
    .err_underflow(err_underflow), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic        rd_ena;
    logic        empty;
    logic [11:0] count;
    logic [15:0] dout;
    logic        clr;
    logic        x_rd_en;
    logic        x_done;
    logic        x_busy;
    logic [15:0] x_ebi;
    logic        x_irq;
    logic        x_uf;
    logic        x_to;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic s_rd_en, s_done, s_busy;

  function automatic void add(input logic a, input logic e, input logic [11:0] c, input logic [15:0] d,
                              input logic cl, input logic xr, input logic xd, input logic xb,
                              input logic [15:0] xe, input logic xi, input logic xu, input logic xt);
    vec_t v;
    v = '{a, e, c, d, cl, xr, xd, xb, xe, xi, xu, xt};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inputs held for one cycle; combinational outputs sampled mid-cycle, registers after the edge
  task automatic cyc(input logic a, input logic e, input logic [11:0] c, input logic [15:0] d, input logic cl);
    bus.rd_ena     = a;
    bus.fifo_empty = e;
    bus.fifo_count = c;
    bus.fifo_dout  = d;
    err_clr        = cl;
    @(negedge rd_clk);
    s_rd_en = bus.fifo_rd_en;
    s_done  = frame_done;
    s_busy  = busy;
    @(posedge rd_clk);
    #1;
  endtask

  initial begin
    int pops;
    int dones;
    rd_rst_n = 1'b0;
    bus.rd_ena = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_count = '0; bus.fifo_dout = '0; err_clr = 1'b0;

    // normal frame of 4
    add(0,0,4,16'h0001,0, 0,0,0,16'h0000,1,0,0);
    add(1,0,4,16'h0001,0, 1,0,1,16'h0001,0,0,0);
    add(0,0,3,16'h0002,0, 0,0,1,16'h0001,0,0,0);
    add(1,0,3,16'h0002,0, 1,0,1,16'h0002,0,0,0);
    add(0,0,2,16'h0003,0, 0,0,1,16'h0002,0,0,0);
    add(1,0,2,16'h0003,0, 1,0,1,16'h0003,0,0,0);
    add(0,0,1,16'h0004,0, 0,0,1,16'h0003,0,0,0);
    add(1,0,1,16'h0004,0, 1,0,1,16'h0004,0,0,0);
    add(0,1,0,16'h0000,0, 0,1,1,16'h0004,0,0,0);
    add(0,1,0,16'h0000,0, 0,0,0,16'h0004,0,0,0);
    // stray reads in IDLE and err_clr interplay
    add(1,1,0,16'h0000,0, 0,0,0,16'hDEAD,0,1,0);
    add(0,1,0,16'h0000,0, 0,0,0,16'hDEAD,0,1,0);
    add(1,1,0,16'h0000,1, 0,0,0,16'hDEAD,0,1,0);
    add(0,1,0,16'h0000,1, 0,0,0,16'hDEAD,0,0,0);
    // frame armed on a forced count with only 2 words present
    add(0,0,4,16'h0011,0, 0,0,0,16'hDEAD,1,0,0);
    add(1,0,4,16'h0011,0, 1,0,1,16'h0011,0,0,0);
    add(0,0,4,16'h0012,0, 0,0,1,16'h0011,0,0,0);
    add(1,0,4,16'h0012,0, 1,0,1,16'h0012,0,0,0);
    add(0,1,4,16'h0000,0, 0,0,1,16'h0012,0,0,0);
    add(1,1,4,16'h0000,0, 0,0,1,16'hDEAD,0,1,0);
    add(0,1,4,16'h0000,0, 0,0,1,16'hDEAD,0,1,0);
    add(1,1,4,16'h0000,0, 0,0,1,16'hDEAD,0,1,0);
    add(0,1,0,16'h0000,0, 0,1,1,16'hDEAD,0,1,0);
    add(0,1,0,16'h0000,1, 0,0,0,16'hDEAD,0,0,0);

    repeat (3) @(posedge rd_clk);
    #1;
    chk("rst_ebi_dout", bus.ebi_dout, 16'h0000);
    chk("rst_irq", bus.ebi_irq, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_errs", {err_underflow, err_timeout}, 2'b00);
    rd_rst_n = 1'b1;

    pops = 0;
    foreach (vecs[i]) begin
      cyc(vecs[i].rd_ena, vecs[i].empty, vecs[i].count, vecs[i].dout, vecs[i].clr);
      if (i < 10 && s_rd_en) pops++;
      chk($sformatf("v%0d_rd_en", i), s_rd_en, vecs[i].x_rd_en);
      chk($sformatf("v%0d_done", i), s_done, vecs[i].x_done);
      chk($sformatf("v%0d_busy", i), s_busy, vecs[i].x_busy);
      chk($sformatf("v%0d_ebi_dout", i), bus.ebi_dout, vecs[i].x_ebi);
      chk($sformatf("v%0d_irq", i), bus.ebi_irq, vecs[i].x_irq);
      chk($sformatf("v%0d_err_uf", i), err_underflow, vecs[i].x_uf);
      chk($sformatf("v%0d_err_to", i), err_timeout, vecs[i].x_to);
    end
    chk("frame1_pop_count", pops, 4);

    // timeout after two reads, then drain of the remaining two words
    cyc(0,0,4,16'h0021,0);
    chk("to_armed_irq", bus.ebi_irq, 1'b1);
    cyc(1,0,4,16'h0021,0);
    cyc(0,0,3,16'h0022,0);
    cyc(1,0,3,16'h0022,0);
    chk("to_second_read", bus.ebi_dout, 16'h0022);
    dones = 0;
    for (int k = 1; k <= 15; k++) begin
      cyc(0,0,2,16'h0023,0);
      if (s_done) dones++;
      chk($sformatf("to_wait%0d_rd_en", k), s_rd_en, 1'b0);
      chk($sformatf("to_wait%0d_err_to", k), err_timeout, (k == 15));
    end
    cyc(0,0,2,16'h0023,0);
    if (s_done) dones++;
    chk("drain1_rd_en", s_rd_en, 1'b1);
    chk("drain1_busy", s_busy, 1'b1);
    cyc(0,0,1,16'h0024,0);
    if (s_done) dones++;
    chk("drain2_rd_en", s_rd_en, 1'b1);
    cyc(0,1,0,16'h0000,0);
    if (s_done) dones++;
    chk("drain_idle_busy", s_busy, 1'b0);
    chk("drain_idle_rd_en", s_rd_en, 1'b0);
    chk("drain_no_done", dones, 0);
    chk("drain_ebi_unchanged", bus.ebi_dout, 16'h0022);
    chk("drain_err_to_sticky", err_timeout, 1'b1);

    // reset asserted mid-READING with word_cnt=2
    cyc(0,0,4,16'h0031,0);
    cyc(1,0,4,16'h0031,0);
    cyc(0,0,3,16'h0032,0);
    cyc(1,0,3,16'h0032,0);
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    bus.rd_ena = 1'b0;
    rd_rst_n = 1'b0;
    #1;
    chk("mid_rst_ebi_dout", bus.ebi_dout, 16'h0000);
    chk("mid_rst_irq", bus.ebi_irq, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd_en", bus.fifo_rd_en, 1'b0);
    chk("mid_rst_errs", {err_underflow, err_timeout}, 2'b00);
    @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
    cyc(0,0,8,16'h0041,0);
    chk("post_rst_irq", bus.ebi_irq, 1'b1);

    // NRDE held low for 20 cycles yields a single pop
    pops = 0;
    cyc(1,0,8,16'h0041,0);
    if (s_rd_en) pops++;
    chk("hold_first_word", bus.ebi_dout, 16'h0041);
    for (int k = 1; k < 20; k++) begin
      cyc(1,1,0,16'h0000,0);
      if (s_rd_en) pops++;
    end
    chk("hold_pop_count", pops, 1);
    chk("hold_no_underflow", err_underflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/anchor_ebi_rd_ctrl.md
Name: anchor_ebi_rd_ctrl

Overview:
- Read-side frame controller for the anchor external bus interface (EBI). Sits in the rd_clk domain, after the read-enable synchronizer, between the sample FIFO and the MCU.
- Raises an interrupt when a full frame is buffered, then pops one FIFO word per MCU read strobe onto the EBI data register.
- Handles underflow, stray reads and MCU stalls; a stalled frame is timed out and drained so frame alignment is preserved.

Parameters:
- DATA_W, 16: EBI/FIFO word width.
- CNT_W, 12: width of fifo_count.
- FRAME_WORDS, 64: words per frame (1..2^CNT_W-1).
- TIMEOUT, 65535: max rd_clk cycles between MCU read strobes inside a frame (>=2).
- UNDERFLOW_WORD, 16'hDEAD: value driven on the EBI when no valid word is available.

Ports:
- rd_clk  in  1  read-domain clock.
- rd_rst_n  in  1  asynchronous, active-low reset.
- rd_ena  in  1  synchronized MCU read enable, high while NRDE is low.
- fifo_dout  in  DATA_W  FIFO head word, first-word-fall-through, valid when !fifo_empty.
- fifo_empty  in  1  FIFO empty.
- fifo_count  in  CNT_W  words held in FIFO.
- fifo_rd_en  out  1  FIFO pop, one word per high cycle.
- ebi_dout  out  DATA_W  registered word presented to the EBI.
- ebi_irq  out  1  frame-ready interrupt, level.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.
- err_underflow  out  1  sticky: a read had no valid word.
- err_timeout  out  1  sticky: frame aborted by timeout.
- err_clr  in  1  clears both sticky errors.

Behaviour:
- Reset (async assert, rd_clk-synchronous release):
  - state=IDLE; ebi_dout=0; ebi_irq=0; frame_done=0; both errors=0; counters=0; rd_ena_q=0.
- Strobe detection: rd_ena registered into rd_ena_q; strobe = rd_ena & ~rd_ena_q, at most one per NRDE assertion.
- fifo_rd_en is combinational: strobe & (ARMED|READING) & !fifo_empty, or the drain condition below.
- On a popping strobe in cycle N, ebi_dout takes fifo_dout at the end of N (visible in N+1). Read latency is 3 rd_clk from raw NRDE fall (2 sync + 1 output register); the MCU read timing must cover this.
- States:
  - IDLE:
    - fifo_count >= FRAME_WORDS: go to ARMED; ebi_irq=1 from the next cycle.
    - Strobe in IDLE (stray read): ebi_dout<=UNDERFLOW_WORD, err_underflow set, no pop.
  - ARMED:
    - ebi_irq held high.
    - First strobe: pop, word_cnt<=1, ebi_irq<=0, go to READING (DONE if FRAME_WORDS==1).
    - No timeout applies while ARMED.
  - READING:
    - Each strobe increments word_cnt and clears to_cnt. It pops if !fifo_empty; otherwise ebi_dout<=UNDERFLOW_WORD and err_underflow set. word_cnt increments either way.
    - word_cnt reaching FRAME_WORDS: go to DONE.
    - to_cnt increments every cycle without a strobe. Reaching TIMEOUT-1: err_timeout set, go to DRAIN.
  - DRAIN:
    - fifo_rd_en=1 on every cycle with !fifo_empty; word_cnt increments per pop.
    - word_cnt reaching FRAME_WORDS: go to IDLE. No frame_done pulse.
    - Empty FIFO: wait, with no timeout.
    - Strobes during DRAIN: ebi_dout<=UNDERFLOW_WORD, err_underflow set, and they do not increment word_cnt.
  - DONE: frame_done=1 for exactly this cycle, word_cnt<=0, go to IDLE.
- Back-to-back frames: IDLE re-evaluates fifo_count the cycle after DONE, so ebi_irq re-asserts 2 cycles after frame_done if a frame is already buffered.
- Errors: err_clr clears both sticky flags. A new error event in the same cycle as err_clr wins (flag stays 1).
- Counters: word_cnt is clog2(FRAME_WORDS+1) bits, to_cnt is clog2(TIMEOUT) bits. Neither may wrap: both saturate by construction of the transitions.
- Reset mid-frame: controller returns to IDLE. Any partial frame left in the FIFO is not drained (the FIFO is reset by the same source).

Test Plan:
- FRAME_WORDS=4, FIFO preloaded with 0x0001..0x0004 -> ebi_irq=1 one cycle after fifo_count>=4; 4 NRDE pulses -> ebi_dout reads 0x0001,0x0002,0x0003,0x0004; ebi_irq drops on the first strobe; one frame_done pulse; fifo_rd_en high exactly 4 cycles.
- Frame of 4 with only 2 words present (force fifo_count) -> reads 3 and 4 return 0xDEAD; err_underflow=1; frame_done still pulses.
- TIMEOUT=16, stop after 2 reads with 4 words buffered -> err_timeout=1 at cycle 16 after the last strobe; 2 drain pops on consecutive cycles; back to IDLE; no frame_done.
- NRDE pulse in IDLE with empty FIFO -> ebi_dout=0xDEAD, err_underflow=1, fifo_rd_en stays 0; then err_clr together with a new stray strobe -> flag stays 1; err_clr alone -> 0.
- Assert rd_rst_n low mid-READING (word_cnt=2) -> all outputs at reset values immediately; after release, 8 words buffered -> new frame armed normally.
- NRDE held low 20 cycles -> exactly one pop.
